// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60Hz raster geometry and the coordinate type used by the drawers.
package vga_timing_pkg;

    typedef logic [10:0] coord_t;

    localparam coord_t H_ACTIVE = 11'd640;
    localparam coord_t H_FP     = 11'd16;
    localparam coord_t H_SYNC   = 11'd96;
    localparam coord_t H_TOTAL  = 11'd800;

    localparam coord_t V_ACTIVE = 11'd480;
    localparam coord_t V_FP     = 11'd10;
    localparam coord_t V_SYNC   = 11'd2;
    localparam coord_t V_TOTAL  = 11'd525;

    function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t len);
        return (v >= lo) && (v < coord_t'(lo + len));
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// DLY-deep clk-rate shift register that lines {HS,VS,blankN} up with the registered RGB.
module vga_sync_delay #(
    parameter int             DLY     = 1,
    parameter int             W       = 3,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DLY == 0) begin : g_bypass
            assign q = d;
        end else begin : g_taps
            logic [W-1:0] taps [DLY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DLY; i++) taps[i] <= RST_VAL;
                end else begin
                    taps[0] <= d;
                    for (int i = 1; i < DLY; i++) taps[i] <= taps[i-1];
                end
            end

            assign q = taps[DLY-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel strobe, X/Y counters, delayed sync/blank and frame pulse.
// Optional frame counter port is built when VGA_FRAME_CNT_EN is defined.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int     PIX_DIV         = 2,
    parameter int     PIPE_DLY        = 1,
    // vertical geometry is overridable so short simulations can reach VS and frame wrap
    parameter coord_t V_ACT_LINES     = V_ACTIVE,
    parameter coord_t V_FP_LINES      = V_FP,
    parameter coord_t V_SYNC_LINES    = V_SYNC,
    parameter coord_t V_TOTAL_LINES   = V_TOTAL
) (
    input  logic        clk,
    input  logic        resetN,
    output coord_t      pixelX,
    output coord_t      pixelY,
    output logic        HS,
    output logic        VS,
    output logic        blankN,
    output logic        startOfFrame
`ifdef VGA_FRAME_CNT_EN
    ,output logic [7:0] frameCount
`endif
);

    localparam int              DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] divider;
    logic             strobe;
    logic             line_end;
    logic             frame_end;
    logic             hs_raw;
    logic             vs_raw;
    logic             blank_raw;
    logic [2:0]       sync_q;

    assign strobe    = (divider == DIV_LAST);
    assign line_end  = (pixelX == H_TOTAL - 11'd1);
    assign frame_end = strobe && line_end && (pixelY == V_TOTAL_LINES - 11'd1);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)     divider <= '0;
        else if (strobe) divider <= '0;
        else             divider <= divider + 1'b1;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pixelX <= '0;
            pixelY <= '0;
        end else if (strobe) begin
            if (line_end) begin
                pixelX <= '0;
                pixelY <= (pixelY == V_TOTAL_LINES - 11'd1) ? '0 : pixelY + 11'd1;
            end else begin
                pixelX <= pixelX + 11'd1;
            end
        end
    end

    assign hs_raw    = !in_range(pixelX, H_ACTIVE + H_FP, H_SYNC);
    assign vs_raw    = !in_range(pixelY, V_ACT_LINES + V_FP_LINES, V_SYNC_LINES);
    assign blank_raw = (pixelX < H_ACTIVE) && (pixelY < V_ACT_LINES);

    vga_sync_delay #(
        .DLY     (PIPE_DLY),
        .W       (3),
        .RST_VAL (3'b110)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (resetN),
        .d     ({hs_raw, vs_raw, blank_raw}),
        .q     (sync_q)
    );

    assign {HS, VS, blankN} = sync_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) startOfFrame <= 1'b0;
        else         startOfFrame <= frame_end;
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)        frameCount <= '0;
        else if (frame_end) frameCount <= frameCount + 8'd1;
    end
`endif

endmodule
